fir_coeff_sched: RTL and testbench

Sequencing controller for the 15-tap FIR datapath. Owns a shadow/active pair of 8-bit coefficient banks, presents the active bank to the FIR, gates the input sample stream, and performs glitch-free bank swaps: it stalls input, optionally flushes the FIR tail with zeros, copies shadow to active, and resets the FIR so its warm-up restarts cleanly. It sits between the sample source, a register-style coefficient writer, and the FIR instance.

---
 rtl/fir_coeff_sched.sv | 145 ++++++++++++++
 tb/tb_fir_coeff_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_sched.sv
// Coefficient bank scheduler for the 15-tap FIR: shadow/active banks, input gating, glitch-free swaps.
// Define FIR_COEFF_SCHED_FLUSH_EN to push NUM_COEFFS zero samples through the old bank before a swap.
module fir_coeff_sched #(
  parameter int NUM_COEFFS = 15,
  parameter int DATA_W     = 32,
  parameter int COEF_W     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [DATA_W-1:0]             s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 coeff_wr_en,
  input  logic        [3:0]                    coeff_wr_addr,
  input  logic signed [COEF_W-1:0]             coeff_wr_data,
  input  logic                                 swap_req,
  output logic                                 swap_busy,
  output logic                                 swap_done,
  output logic                                 fir_rst,
  output logic signed [DATA_W-1:0]             fir_data_in,
  output logic                                 fir_data_in_valid,
  output logic        [NUM_COEFFS-1:0][COEF_W-1:0] fir_coeffs,
  input  logic signed [DATA_W-1:0]             fir_data_out,
  input  logic                                 fir_data_out_valid,
  output logic signed [DATA_W-1:0]             m_data,
  output logic                                 m_valid
);

  typedef logic [NUM_COEFFS-1:0][COEF_W-1:0] bank_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
`ifdef FIR_COEFF_SCHED_FLUSH_EN
    FLUSH = 2'd1,
`endif
    SWAP  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'(NUM_COEFFS - 1);

  state_t state, state_nxt;
  bank_t  shadow_bank, active_bank;
  logic   done_p1;
  logic signed [DATA_W-1:0] m_data_p1;
  logic   vld_p1;
`ifdef FIR_COEFF_SCHED_FLUSH_EN
  logic [3:0] flush_cnt;
`endif

  function automatic bank_t identity_bank();
    bank_t b;
    b    = '0;
    b[0] = COEF_W'(1);
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      done_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_p1 <= (state == SWAP);
    end
  end

`ifdef FIR_COEFF_SCHED_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst || state != FLUSH) flush_cnt <= '0;
    else                       flush_cnt <= flush_cnt + 4'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
`ifdef FIR_COEFF_SCHED_FLUSH_EN
        if (swap_req) state_nxt = FLUSH;
`else
        if (swap_req) state_nxt = SWAP;
`endif
      end
`ifdef FIR_COEFF_SCHED_FLUSH_EN
      FLUSH:   if (flush_cnt == LAST_TAP) state_nxt = SWAP;
`endif
      SWAP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are forced to their reset meaning while rst is high, whatever the state.
  always_comb begin
    s_ready           = 1'b0;
    fir_data_in       = '0;
    fir_data_in_valid = 1'b0;
    swap_busy         = 1'b0;
    fir_rst           = rst | (state == SWAP);
    case (state)
      RUN: begin
        s_ready           = ~rst;
        fir_data_in       = s_data;
        fir_data_in_valid = s_valid & ~rst;
      end
`ifdef FIR_COEFF_SCHED_FLUSH_EN
      FLUSH: begin
        fir_data_in_valid = ~rst;
        swap_busy         = ~rst;
      end
`endif
      SWAP:    swap_busy = ~rst;
      default: ;
    endcase
  end

  // Active bank copies the registered shadow, so a write landing in the SWAP cycle stays in shadow only.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_bank <= identity_bank();
      active_bank <= identity_bank();
    end else begin
      if (coeff_wr_en && coeff_wr_addr <= LAST_TAP)
        shadow_bank[coeff_wr_addr] <= coeff_wr_data;
      if (state == SWAP)
        active_bank <= shadow_bank;
    end
  end

  // p1: registered FIR result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      m_data_p1 <= '0;
    end else begin
      vld_p1 <= fir_data_out_valid;
      if (fir_data_out_valid) m_data_p1 <= fir_data_out;
    end
  end

  assign fir_coeffs = active_bank;
  assign swap_done  = done_p1;
  assign m_data     = m_data_p1;
  assign m_valid    = vld_p1;

endmodule

// File: tb/tb_fir_coeff_sched.sv
// Directed self-checking bench for fir_coeff_sched; FIR side is driven directly with hand-picked results.
module tb_fir_coeff_sched;

  localparam int N = 15;
`ifdef FIR_COEFF_SCHED_FLUSH_EN
  localparam int FLUSH_CYC = N;
`else
  localparam int FLUSH_CYC = 0;
`endif

  typedef logic [N-1:0][7:0] bank_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic               coeff_wr_en;
  logic [3:0]         coeff_wr_addr;
  logic signed [7:0]  coeff_wr_data;
  logic               swap_req;
  logic               swap_busy;
  logic               swap_done;
  logic               fir_rst;
  logic signed [31:0] fir_data_in;
  logic               fir_data_in_valid;
  bank_t              fir_coeffs;
  logic signed [31:0] fir_data_out;
  logic               fir_data_out_valid;
  logic signed [31:0] m_data;
  logic               m_valid;

  int n_chk = 0;
  int n_err = 0;
  bank_t ident, exp_bank;

  fir_coeff_sched #(.NUM_COEFFS(N)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
    .swap_req(swap_req), .swap_busy(swap_busy), .swap_done(swap_done),
    .fir_rst(fir_rst), .fir_data_in(fir_data_in), .fir_data_in_valid(fir_data_in_valid),
    .fir_coeffs(fir_coeffs), .fir_data_out(fir_data_out), .fir_data_out_valid(fir_data_out_valid),
    .m_data(m_data), .m_valid(m_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk through the flush window (empty in the default build), checking the zero stream.
  task automatic run_flush(input int stop_at);
    for (int i = 0; i < FLUSH_CYC && i < stop_at; i++) begin
      #1;
      chk("flush_busy", swap_busy, 1'b1);
      chk("flush_ready", s_ready, 1'b0);
      chk("flush_din", fir_data_in, 32'sd0);
      chk("flush_vld", fir_data_in_valid, 1'b1);
      tick();
    end
  endtask

  initial begin
    ident = '0;
    ident[0] = 8'd1;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; coeff_wr_en = 1'b0; coeff_wr_addr = '0;
    coeff_wr_data = '0; swap_req = 1'b0; fir_data_out = '0; fir_data_out_valid = 1'b0;
    tick(); tick();
    #1;
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_fir_rst", fir_rst, 1'b1);
    chk("rst_busy", swap_busy, 1'b0);
    chk("rst_done", swap_done, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mdata", m_data, 32'sd0);
    chk("rst_coeffs", fir_coeffs, ident);

    rst = 1'b0; #1;
    chk("run_ready", s_ready, 1'b1);
    chk("run_fir_rst", fir_rst, 1'b0);
    s_data = 32'sd7; s_valid = 1'b1; #1;
    chk("pass_data", fir_data_in, 32'sd7);
    chk("pass_vld", fir_data_in_valid, 1'b1);
    s_data = -32'sd3; fir_data_out = 32'sd123; fir_data_out_valid = 1'b1; #1;
    chk("pass_neg", fir_data_in, -32'sd3);
    tick();
    chk("out_data", m_data, 32'sd123);
    chk("out_vld", m_valid, 1'b1);
    fir_data_out = 32'sd456; fir_data_out_valid = 1'b0;
    tick();
    chk("out_novld", m_valid, 1'b0);
    chk("out_hold", m_data, 32'sd123);
    fir_data_out = -32'sd77; fir_data_out_valid = 1'b1;
    tick();
    chk("out_negdata", m_data, -32'sd77);
    fir_data_out_valid = 1'b0; s_valid = 1'b0; #1;
    chk("pass_novld", fir_data_in_valid, 1'b0);

    // Load shadow with 2s plus an out-of-range write; active must stay identity.
    for (int i = 0; i < N; i++) begin
      coeff_wr_en = 1'b1; coeff_wr_addr = 4'(i); coeff_wr_data = 8'sd2;
      tick();
    end
    coeff_wr_addr = 4'd15; coeff_wr_data = 8'sh7f;
    tick();
    coeff_wr_en = 1'b0; #1;
    chk("preswap_coeffs", fir_coeffs, ident);
    chk("preswap_busy", swap_busy, 1'b0);

    // Swap request with a same-cycle tap3 write; sample handshake still accepted.
    s_valid = 1'b1; s_data = 32'sd11; swap_req = 1'b1;
    coeff_wr_en = 1'b1; coeff_wr_addr = 4'd3; coeff_wr_data = -8'sd4; #1;
    chk("req_ready", s_ready, 1'b1);
    chk("req_vld", fir_data_in_valid, 1'b1);
    tick();
    swap_req = 1'b0; coeff_wr_en = 1'b0;
    run_flush(N);
    swap_req = 1'b1; coeff_wr_en = 1'b1; coeff_wr_addr = 4'd4; coeff_wr_data = 8'sd9; #1;
    chk("swap_ready", s_ready, 1'b0);
    chk("swap_fir_rst", fir_rst, 1'b1);
    chk("swap_busy", swap_busy, 1'b1);
    chk("swap_dinvld", fir_data_in_valid, 1'b0);
    chk("swap_oldbank", fir_coeffs, ident);
    chk("swap_nodone", swap_done, 1'b0);
    tick();
    swap_req = 1'b0; coeff_wr_en = 1'b0; #1;
    for (int i = 0; i < N; i++) exp_bank[i] = 8'd2;
    exp_bank[3] = 8'hfc;
    chk("done_pulse", swap_done, 1'b1);
    chk("done_busy", swap_busy, 1'b0);
    chk("done_ready", s_ready, 1'b1);
    chk("done_fir_rst", fir_rst, 1'b0);
    chk("newbank", fir_coeffs, exp_bank);
    tick();
    chk("done_once", swap_done, 1'b0);
    chk("noreq_queued", swap_busy, 1'b0);
    chk("noreq_ready", s_ready, 1'b1);

    // Second swap exposes the tap4 write that landed during the first SWAP cycle.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_flush(N);
    chk("swap2_fir_rst", fir_rst, 1'b1);
    tick();
    exp_bank[4] = 8'd9;
    chk("swap2_done", swap_done, 1'b1);
    chk("swap2_bank", fir_coeffs, exp_bank);
    tick();

    // Reset in the middle of a swap (flush count 6, or the SWAP cycle in the default build).
    fir_data_out = 32'sd55; fir_data_out_valid = 1'b1; s_valid = 1'b0; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_flush(6);
    chk("pre_rst_busy", swap_busy, 1'b1);
    chk("pre_rst_mvalid", m_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_coeffs", fir_coeffs, ident);
    chk("midrst_busy", swap_busy, 1'b0);
    chk("midrst_mvalid", m_valid, 1'b0);
    chk("midrst_mdata", m_data, 32'sd0);
    chk("midrst_done", swap_done, 1'b0);
    rst = 1'b0; fir_data_out_valid = 1'b0;
    tick();
    chk("postrst_done", swap_done, 1'b0);
    chk("postrst_busy", swap_busy, 1'b0);
    chk("postrst_ready", s_ready, 1'b1);

    // Shadow must also be identity again: a fresh swap leaves the active bank at identity.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    run_flush(N);
    tick();
    chk("postrst_swap_done", swap_done, 1'b1);
    chk("postrst_shadow", fir_coeffs, ident);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
